// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: default width, opcodes, FSM states, flag positions.
package alu_pipe_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SLTS = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MULH = 4'd11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
module alu_mul_seq import alu_pipe_pkg::*; #(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   a,
  input  logic [WORD_SIZE-1:0]   b,
  output logic                   done,
  output logic [2*WORD_SIZE-1:0] product
);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE - 1);

  logic [2*WORD_SIZE-1:0] mcand;
  logic [2*WORD_SIZE-1:0] acc;
  logic [2*WORD_SIZE-1:0] acc_next;
  logic [WORD_SIZE-1:0]   mplier;
  logic [CNT_W-1:0]       cnt;
  logic                   busy;

  // done/product expose the final iteration combinationally so the caller
  // can register the result on the same edge the last bit is consumed.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WORD_SIZE{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, Z/N/C/V flags and a sequential multiplier.
module alu_pipe import alu_pipe_pkg::*; #(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] in1,
  input  logic [WORD_SIZE-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out,
  output logic [3:0]           flags,
  output logic                 illegal
);

  localparam int SHAMT_W = $clog2(WORD_SIZE);
  localparam int MSB     = WORD_SIZE - 1;

  state_t                 state;
  logic                   accept;
  logic                   is_mul;
  logic                   mul_high;
  logic                   mul_done;
  logic [2*WORD_SIZE-1:0] product;
  logic [WORD_SIZE-1:0]   mul_res;
  logic [3:0]             mul_flags;
  logic [SHAMT_W-1:0]     shamt;
  logic [WORD_SIZE:0]     sum;
  logic [WORD_SIZE:0]     diff;
  logic [WORD_SIZE-1:0]   res;
  logic [3:0]             res_flags;
  logic                   res_illegal;
  logic                   c;
  logic                   v;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == ALU_MUL) || (op == ALU_MULH);
  assign shamt     = in2[SHAMT_W-1:0];
  assign sum       = {1'b0, in1} + {1'b0, in2};
  assign diff      = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    res         = '0;
    c           = 1'b0;
    v           = 1'b0;
    res_illegal = 1'b0;
    case (op)
      ALU_ADD: begin
        res = sum[WORD_SIZE-1:0];
        c   = sum[WORD_SIZE];
        v   = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
      end
      ALU_SUB: begin
        res = diff[WORD_SIZE-1:0];
        c   = diff[WORD_SIZE];
        v   = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
      end
      ALU_SLT:  res = WORD_SIZE'(in1 < in2);
      ALU_AND:  res = in1 & in2;
      ALU_OR:   res = in1 | in2;
      ALU_XOR:  res = in1 ^ in2;
      ALU_SLL:  res = in1 << shamt;
      ALU_SLTS: res = WORD_SIZE'($signed(in1) < $signed(in2));
      ALU_SRL:  res = in1 >> shamt;
      ALU_SRA:  res = $unsigned($signed(in1) >>> shamt);
      ALU_MUL, ALU_MULH: res = '0;
      default:  res_illegal = 1'b1;
    endcase

    res_flags = '0;
    if (!res_illegal) begin
      res_flags[FLAG_Z] = (res == '0);
      res_flags[FLAG_N] = res[MSB];
      res_flags[FLAG_C] = c;
      res_flags[FLAG_V] = v;
    end
  end

  always_comb begin
    mul_res           = mul_high ? product[2*WORD_SIZE-1:WORD_SIZE] : product[WORD_SIZE-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_res == '0);
    mul_flags[FLAG_N] = mul_res[MSB];
    mul_flags[FLAG_C] = |product[2*WORD_SIZE-1:WORD_SIZE];
  end

  alu_mul_seq #(
    .WORD_SIZE (WORD_SIZE)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out      <= '0;
      flags    <= '0;
      illegal  <= 1'b0;
      mul_high <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE share the accept path; DONE accepts only when the
        // current result is consumed in the same cycle (in_ready gates that).
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              state    <= MUL;
              mul_high <= (op == ALU_MULH);
            end else begin
              state   <= DONE;
              out     <= res;
              flags   <= res_flags;
              illegal <= res_illegal;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (mul_done) begin
            state   <= DONE;
            out     <= mul_res;
            flags   <= mul_flags;
            illegal <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WORD_SIZE=16.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [3:0]  flags;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_pipe #(
    .WORD_SIZE (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1, scramble inputs after accept, wait for
  // the result and check latency, busy cycles, result, flags and drain.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_out,
                        input logic [3:0] exp_flags, input logic exp_ill,
                        input int exp_lat, input int exp_busy);
    int n;
    int nb;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = o;
    in1       = a;
    in2       = b;
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    op       = 4'd0;
    in1      = 16'hFFFF;
    in2      = 16'hFFFF;
    n  = 1;
    nb = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) nb++;
      step();
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".busy"}, 32'(nb), 32'(exp_busy));
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".flags"}, 32'(flags), 32'(exp_flags));
    check({tag, ".ill"}, 32'(illegal), 32'(exp_ill));
    step();
    check({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    in1       = '0;
    in2       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.out", 32'(out), 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    check("rst.ill", 32'(illegal), 32'd0);

    // flags = {Z,N,C,V}
    run_op("add_ovf", 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1, 0);
    run_op("add_cry", 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 1, 0);
    run_op("sub_brw", 4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0, 1, 0);
    run_op("sub_ovf", 4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 1, 0);
    run_op("slts",    4'd8,  16'hFFFF, 16'h0001, 16'h0001, 4'b0000, 1'b0, 1, 0);
    run_op("slt",     4'd3,  16'hFFFF, 16'h0001, 16'h0000, 4'b1000, 1'b0, 1, 0);
    run_op("sra",     4'd10, 16'h8000, 16'h0013, 16'hF000, 4'b0100, 1'b0, 1, 0);
    run_op("srl",     4'd9,  16'h8000, 16'h0013, 16'h1000, 4'b0000, 1'b0, 1, 0);
    run_op("sll0",    4'd7,  16'h0001, 16'h0000, 16'h0001, 4'b0000, 1'b0, 1, 0);
    run_op("or",      4'd5,  16'hA000, 16'h0005, 16'hA005, 4'b0100, 1'b0, 1, 0);
    run_op("mul",     4'd2,  16'h1234, 16'h0100, 16'h3400, 4'b0010, 1'b0, 17, 16);
    run_op("mulh",    4'd11, 16'h1234, 16'h0100, 16'h0012, 4'b0010, 1'b0, 17, 16);
    run_op("mul_sm",  4'd2,  16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 17, 16);
    run_op("ill13",   4'd13, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1, 1, 0);

    // Backpressure: result must hold while out_ready=0.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 4'd6;
    in1       = 16'hFF00;
    in2       = 16'h0FF0;
    step();
    in_valid = 1'b0;
    in1      = 16'h1111;
    in2      = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.out", 32'(out), 32'hF0F0);
      check("bp.ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b1;
    op        = 4'd4;
    in1       = 16'hFF0F;
    in2       = 16'h00FF;
    out_ready = 1'b1;
    #1;
    check("b2b.ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b.valid", 32'(out_valid), 32'd1);
    check("b2b.out", 32'(out), 32'h000F);
    check("b2b.flags", 32'(flags), 32'd0);
    step();
    check("b2b.drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply aborts it with no result.
    in_valid = 1'b1;
    op       = 4'd2;
    in1      = 16'h1234;
    in2      = 16'h0100;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("mrst.busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.ready", 32'(in_ready), 32'd1);
    check("mrst.out", 32'(out), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n++;
      step();
    end
    check("mrst.noresult", 32'(n), 32'd0);

    run_op("ill15", 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b0 | 1'b1, 1, 0);
    run_op("add_pr", 4'd0, 16'h0010, 16'h0020, 16'h0030, 4'b0000, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the single-cycle ALU.
- Width set by WORD_SIZE. 4-bit opcode adds signed compare, logical and arithmetic right shifts, and a high-half multiply.
- Produces Z/N/C/V flags.
- Has a valid/ready handshake on both sides, and an iterative shift-add multiplier so MUL/MULH take WORD_SIZE+1 cycles without a wide combinational multiplier.
- Sits between decode/operand fetch and writeback; holds one operation in flight.

Parameters:
- WORD_SIZE, 16, operand/result width in bits; must be ≥4 and a power of 2.
- SHAMT_W, $clog2(WORD_SIZE), shift-amount bits taken from in2; derived, not overridden.

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- op  input  4  opcode (ALU_* constants)
- in1  input  WORD_SIZE  operand A
- in2  input  WORD_SIZE  operand B / shift amount
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result this cycle
- out  output  WORD_SIZE  registered result
- flags  output  4  {Z,N,C,V}, registered with out
- illegal  output  1  opcode 12..15 seen; registered with out

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out=0, flags=0, illegal=0, out_valid=0, in_ready=1. Reset wins over all other inputs and aborts an in-progress multiply; no result is produced for it.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - out/flags/illegal are stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: in_ready=1, out_valid=0. A non-multiply accept registers the result, goes to DONE, and sets out_valid=1 next cycle (latency 1). MUL/MULH accept latches operands, clears the accumulator and counter, and goes to MUL.
  - MUL: in_ready=0. One bit of in2 per cycle, LSB first, with a 2*WORD_SIZE-bit accumulator. After WORD_SIZE iterations, register the result and go to DONE. Accept-to-out_valid latency is WORD_SIZE+1 cycles.
  - DONE: out_valid=1, in_ready=out_ready. If out_ready=1 and in_valid=1 in the same cycle, the new op is accepted (back-to-back). Non-multiply ops then stay in DONE with the new result; multiply ops go to MUL. If out_ready=1 and in_valid=0, go to IDLE. If out_ready=0, hold.
- in_ready is combinational from state and out_ready only, never from in_valid.
- Opcodes and results:
  - 0 ADD: in1+in2
  - 1 SUB: in1-in2
  - 2 MUL: low half of the unsigned product
  - 3 SLT: unsigned in1<in2 → 1/0
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SLL: in1<<in2[SHAMT_W-1:0]
  - 8 SLTS: signed in1<in2 → 1/0
  - 9 SRL
  - 10 SRA: sign-filling right shift
  - 11 MULH: high half of the unsigned product
  - 12..15: out=0, illegal=1, flags=0, latency 1
- Shift amount uses only in2[SHAMT_W-1:0]; upper bits are ignored. A shift by 0 returns in1.
- Flags:
  - Z = (out==0). N = out[WORD_SIZE-1].
  - C: ADD carry-out; SUB borrow (1 iff in1<in2 unsigned); MUL/MULH 1 iff the high half is nonzero; 0 for all other ops.
  - V: signed overflow for ADD/SUB only, else 0.
- Wrap-around: ADD/SUB/MUL results are truncated to WORD_SIZE modulo 2^WORD_SIZE.
- Operands are sampled only at accept. Later changes to in1/in2/op have no effect.

Decomposition:
- Shared package/header (extends parameters.vh): WORD_SIZE default; ALU_* opcode constants 0..11 at 4 bits; state encoding IDLE/MUL/DONE; FLAG_Z/N/C/V bit indices (3..0).
- One sub-module, alu_mul_seq: start/operands in, done/product out, iterative shift-add multiplier. Everything else stays in alu_pipe.

Test Plan:
- Reset then ADD 0x7FFF+0x0001 (W=16), out_ready=1 → out_valid one cycle after accept; out=0x8000, flags N=1, V=1, C=0, Z=0.
- SUB 0x0003-0x0005 → out=0xFFFE, C=1, N=1, V=0. SLTS 0xFFFF,0x0001 → 1. SLT same operands → 0.
- SRA 0x8000 by in2=0x0013 (shamt 3) → 0xF000. SRL same → 0x1000. SLL 0x0001 by 0 → 0x0001.
- MUL 0x1234*0x0100 → in_ready=0 for 16 cycles, out_valid at cycle 17, out=0x3400, C=1. MULH same → 0x0012.
- Backpressure: hold out_ready=0 for 5 cycles after XOR 0xFF00^0x0FF0 → out=0xF0F0 stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND) → accepted the same cycle; next out_valid on the following cycle.
- Assert reset mid-MUL (cycle 8) → next cycle out_valid=0, in_ready=1, out=0. Op 13 → illegal=1, out=0.
